// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : inst_fetch_ctrl_pkg
//  Brief  : Shared fetch-path widths, exception codes and PC helpers.
//  Rev    : 1.0  initial release
// ============================================================================
package inst_fetch_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam int EXC_CODE_BUS  = 5;

  typedef logic [EXC_CODE_BUS-1:0] exc_code_t;

  localparam exc_code_t                EXC_NONE = 5'h10;
  localparam exc_code_t                EXC_ADEL = 5'h04;
  localparam logic [INST_ADDR_BUS-1:0] PC_INIT  = 32'hBFC0_0000;

  function automatic logic pc_aligned(input logic [INST_ADDR_BUS-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

  // Wraps modulo 2^32 by construction of the result width.
  function automatic logic [INST_ADDR_BUS-1:0] pc_plus_4(input logic [INST_ADDR_BUS-1:0] pc);
    return pc + INST_ADDR_BUS'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : inst_fetch_ctrl
//  Brief  : IF-stage controller bridging the PC stage to an SRAM-like bus.
//  Rev    : 1.0  initial release
// ============================================================================
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
(
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst_n,
  input  logic [INST_ADDR_BUS-1:0] fetch_pc,
  input  logic                     fetch_en,
  input  logic                     id_stall,
  input  logic                     flush,
  output logic                     inst_req,
  output logic [INST_ADDR_BUS-1:0] inst_addr,
  input  logic                     inst_addr_ok,
  input  logic                     inst_data_ok,
  input  logic [INST_BUS-1:0]      inst_rdata,
  output logic [INST_ADDR_BUS-1:0] if_pc,
  output logic [INST_ADDR_BUS-1:0] if_pc_plus_4,
  output logic [INST_BUS-1:0]      if_inst,
  output logic                     if_inst_data_ok,
  output exc_code_t                if_exccode,
  output logic                     stall_req_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t r_state;
  logic   r_kill;

  // The if_* registers double as the result buffer; HOLD means "result ready".
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state      <= S_IDLE;
      r_kill       <= 1'b0;
      inst_req     <= 1'b0;
      inst_addr    <= '0;
      if_pc        <= PC_INIT;
      if_pc_plus_4 <= PC_INIT;
      if_inst      <= '0;
      if_exccode   <= EXC_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_en && !flush) begin
            if (pc_aligned(fetch_pc)) begin
              inst_req  <= 1'b1;
              inst_addr <= fetch_pc;
              r_state   <= S_REQ;
            end else begin
              if_pc        <= fetch_pc;
              if_pc_plus_4 <= pc_plus_4(fetch_pc);
              if_inst      <= '0;
              if_exccode   <= EXC_ADEL;
              r_state      <= S_HOLD;
            end
          end
        end
        S_REQ: begin
          if (flush) r_kill <= 1'b1;
          if (inst_addr_ok) begin
            inst_req <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            r_kill <= 1'b0;
            if (r_kill || flush) begin
              r_state <= S_IDLE;
            end else begin
              if_pc        <= inst_addr;
              if_pc_plus_4 <= pc_plus_4(inst_addr);
              if_inst      <= inst_rdata;
              if_exccode   <= EXC_NONE;
              r_state      <= S_HOLD;
            end
          end else if (flush) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush || !id_stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe follows id_stall in the same cycle so the IF/ID register takes the
  // result in exactly the first cycle it is able to.
  assign if_inst_data_ok = (r_state == S_HOLD) && !id_stall && !flush;
  assign stall_req_if    = (r_state == S_REQ) || (r_state == S_WAIT) || r_kill;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_inst_fetch_ctrl
//  Brief  : Directed and randomized self-checking bench for inst_fetch_ctrl.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n   = 1'b1;
  logic [31:0] fetch_pc    = '0;
  logic        fetch_en    = 1'b0;
  logic        id_stall    = 1'b0;
  logic        flush       = 1'b0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata  = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_inst;
  logic        if_inst_data_ok;
  exc_code_t   if_exccode;
  logic        stall_req_if;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_fetch_ctrl dut (
    .cpu_clk_50M     (cpu_clk_50M),
    .cpu_rst_n       (cpu_rst_n),
    .fetch_pc        (fetch_pc),
    .fetch_en        (fetch_en),
    .id_stall        (id_stall),
    .flush           (flush),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .if_pc           (if_pc),
    .if_pc_plus_4    (if_pc_plus_4),
    .if_inst         (if_inst),
    .if_inst_data_ok (if_inst_data_ok),
    .if_exccode      (if_exccode),
    .stall_req_if    (stall_req_if)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".inst_req"},        32'(inst_req),        32'd0);
    check({tag, ".inst_addr"},       inst_addr,            32'd0);
    check({tag, ".if_pc"},           if_pc,                PC_INIT);
    check({tag, ".if_pc_plus_4"},    if_pc_plus_4,         PC_INIT);
    check({tag, ".if_inst"},         if_inst,              32'd0);
    check({tag, ".if_inst_data_ok"}, 32'(if_inst_data_ok), 32'd0);
    check({tag, ".if_exccode"},      32'(if_exccode),      32'(EXC_NONE));
    check({tag, ".stall_req_if"},    32'(stall_req_if),    32'd0);
  endtask

  // One fetch, cycle 0 = the cycle fetch_en is presented. Expected behaviour
  // is derived from the transaction parameters: when data returns, when the
  // IF/ID register is free, and whether a flush lands before delivery.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] rdata,
                           input int a_lat, input int d_lat, input int stall_len,
                           input int flush_cyc, input bit spur);
    bit aligned, started, strobe_exp, req_exp, stall_exp, stb_now;
    int d_cyc, deliv, n_cyc;
    aligned    = (pc[1:0] == 2'b00);
    started    = (flush_cyc != 0);
    d_cyc      = aligned ? (1 + a_lat + d_lat) : 0;
    deliv      = d_cyc + ((stall_len > 1) ? stall_len : 1);
    strobe_exp = started && ((flush_cyc < 0) || (flush_cyc > deliv));
    n_cyc      = started ? (deliv + 2) : 3;
    for (int c = 0; c < n_cyc; c++) begin
      fetch_en     = (c == 0);
      fetch_pc     = pc;
      flush        = (c == flush_cyc);
      id_stall     = (c >= d_cyc) && (c < d_cyc + stall_len);
      inst_addr_ok = started && aligned && (c == 1 + a_lat);
      inst_data_ok = (started && aligned && (c == d_cyc)) || (spur && c == 0) ||
                     (spur && aligned && a_lat > 0 && c == 1);
      inst_rdata   = (aligned && c == d_cyc) ? rdata : $urandom();
      @(negedge cpu_clk_50M);
      req_exp   = started && aligned && (c >= 1) && (c <= 1 + a_lat);
      stall_exp = started && aligned && (c >= 1) && (c <= d_cyc);
      stb_now   = strobe_exp && (c == deliv);
      check("inst_req", 32'(inst_req), 32'(req_exp));
      if (req_exp) check("inst_addr", inst_addr, pc);
      check("stall_req_if", 32'(stall_req_if), 32'(stall_exp));
      check("if_inst_data_ok", 32'(if_inst_data_ok), 32'(stb_now));
      if (stb_now) begin
        check("if_pc", if_pc, pc);
        check("if_pc_plus_4", if_pc_plus_4, pc + 32'd4);
        check("if_inst", if_inst, aligned ? rdata : 32'd0);
        check("if_exccode", 32'(if_exccode), aligned ? 32'(EXC_NONE) : 32'(EXC_ADEL));
      end
      @(posedge cpu_clk_50M);
      #1;
    end
    fetch_en     = 1'b0;
    flush        = 1'b0;
    id_stall     = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    int a, d, s, fl;

    #3 cpu_rst_n = 1'b0;
    #1 check_reset_vals("por");
    repeat (2) @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M);
    #1;

    run_fetch(32'hBFC0_0000, 32'h2401_0001, 2, 3, 0, -1, 1'b0);  // basic fetch
    run_fetch(32'hBFC0_0004, $urandom(),    1, 2, 4, -1, 1'b0);  // stall over data_ok
    run_fetch(32'hBFC0_0010, $urandom(),    1, 4, 0,  3, 1'b0);  // flush after addr_ok
    run_fetch(32'hBFC0_0380, $urandom(),    1, 1, 0, -1, 1'b0);
    run_fetch(32'hBFC0_0002, $urandom(),    0, 1, 0, -1, 1'b0);  // misaligned
    run_fetch(32'hBFC0_0003, $urandom(),    0, 1, 3, -1, 1'b0);  // misaligned, stalled
    run_fetch(32'hFFFF_FFFC, $urandom(),    0, 1, 0, -1, 1'b0);  // PC+4 wraps
    run_fetch(32'hBFC0_0020, $urandom(),    0, 1, 0,  0, 1'b0);  // flush beats fetch
    run_fetch(32'hBFC0_0024, $urandom(),    1, 2, 0,  4, 1'b0);  // flush with data_ok
    run_fetch(32'hBFC0_0028, $urandom(),    0, 1, 3,  3, 1'b0);  // flush in HOLD
    run_fetch(32'hBFC0_002C, $urandom(),    2, 2, 0,  1, 1'b1);  // flush in REQ, spurious data_ok

    // Reset while the bus read is outstanding.
    fetch_en = 1'b1;
    fetch_pc = 32'hBFC0_0040;
    @(posedge cpu_clk_50M);
    #1;
    fetch_en     = 1'b0;
    inst_addr_ok = 1'b1;
    @(negedge cpu_clk_50M);
    check("midrst.inst_req", 32'(inst_req), 32'd1);
    @(posedge cpu_clk_50M);
    #1;
    inst_addr_ok = 1'b0;
    @(negedge cpu_clk_50M);
    check("midrst.stall_wait", 32'(stall_req_if), 32'd1);
    #2 cpu_rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M);
    #1;
    run_fetch(32'hBFC0_0044, $urandom(), 0, 2, 0, -1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      pc = $urandom();
      pc[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, 4));
      s = int'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) fl = int'($urandom_range(0, 1 + a + d + s));
      else                           fl = -1;
      run_fetch(pc, $urandom(), a, d, s, fl, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Interface SHALL use one clock and an asynchronous, active-low reset: cpu_clk_50M and cpu_rst_n.
REQ-002 cpu_clk_50M  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 cpu_rst_n  in  1  asynchronous active-low reset.
REQ-004 fetch_pc  in  INST_ADDR_BUS (32)  address of the next instruction to fetch.
REQ-005 fetch_en  in  1  PC stage requests a new fetch.
REQ-006 id_stall  in  1  IF/ID register cannot accept (stall[2] stopped).
REQ-007 flush  in  1  pipeline flush; all in-flight fetch results are discarded.
REQ-008 inst_req  out  1  SRAM-like instruction request to the AXI bridge.
REQ-009 inst_addr  out  32  request address.
REQ-010 inst_addr_ok  in  1  bridge accepted the address.
REQ-011 inst_data_ok  in  1  bridge returns read data.
REQ-012 inst_rdata  in  INST_BUS (32)  returned instruction.
REQ-013 if_pc, if_pc_plus_4  out  32  PC of the delivered instruction and PC+4 (mod 2^32).
REQ-014 if_inst  out  32  delivered instruction.
REQ-015 if_inst_data_ok  out  1  one-cycle delivery strobe to the IF/ID register.
REQ-016 if_exccode  out  EXC_CODE_BUS  EXC_NONE, or EXC_ADEL for a misaligned PC.
REQ-017 stall_req_if  out  1  fetch incomplete; stall controller holds PC and IF.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, WAIT and HOLD, plus a kill flag.
REQ-021 IDLE: if fetch_en=1, flush=0 and fetch_pc[1:0]=0, the block SHALL latch fetch_pc and go to REQ.
REQ-022 IDLE with fetch_en=1 and fetch_pc[1:0]≠0: no bus request; EXC_ADEL result delivered as in REQ-025/026, with if_inst=0.
REQ-023 REQ: inst_req=1 and inst_addr=latched PC, held stable until inst_addr_ok=1, then go to WAIT; a request SHALL never be withdrawn before inst_addr_ok.
REQ-024 WAIT: on inst_data_ok=1, inst_rdata SHALL be captured.
REQ-025 Delivery: with captured data and id_stall=0, if_inst_data_ok=1 for exactly one cycle, with if_pc, if_inst and if_exccode valid in that cycle; the FSM then goes to IDLE.
REQ-026 Captured data with id_stall=1: go to HOLD and keep data; deliver in the first cycle id_stall=0.
REQ-027 Earliest delivery SHALL be the cycle after inst_data_ok; the next request SHALL be no earlier than the cycle after delivery.
REQ-028 stall_req_if SHALL be 1 in REQ and WAIT, and while kill=1; it SHALL be 0 in IDLE and HOLD.
REQ-029 flush in REQ or WAIT SHALL set kill; the bus transaction still completes; the data_ok data is dropped (no strobe); kill clears and the FSM goes to IDLE.
REQ-030 flush in the same cycle as inst_data_ok SHALL drop that data.
REQ-031 flush in HOLD SHALL discard the buffer and go to IDLE with no strobe.
REQ-032 flush SHALL have priority over a new fetch in IDLE; no request is issued in the flush cycle.
REQ-033 inst_data_ok in IDLE/REQ with kill=0 SHALL be ignored (protocol error, no state change).

Reset
REQ-040 cpu_rst_n=0 SHALL immediately force:
- state=IDLE, kill=0
- inst_req=0, inst_addr=0
- if_pc=PC_INIT, if_pc_plus_4=PC_INIT
- if_inst=0, if_inst_data_ok=0
- if_exccode=EXC_NONE, stall_req_if=0
REQ-041 Reset mid-transaction SHALL abandon it; the bridge is reset by the same cpu_rst_n.

Structure
REQ-050 INST_ADDR_BUS, INST_BUS, EXC_CODE_BUS, EXC_NONE, EXC_ADEL and PC_INIT SHALL come from the shared defines.v.
REQ-051 FSM state encodings SHALL be local to the module; no sub-module.

Verification
REQ-060 Fetch 0xBFC00000: addr_ok after 2 cycles, data_ok after 3 more with rdata 0x24010001 -> one strobe; if_pc=0xBFC00000, if_pc_plus_4=0xBFC00004.
REQ-061 id_stall=1 for 4 cycles over data_ok -> HOLD, stall_req_if=0, single strobe in the first cycle id_stall=0, inst unchanged.
REQ-062 flush one cycle after addr_ok, data_ok 3 cycles later -> no strobe; stall_req_if=1 until data_ok; next fetch 0xBFC00380 delivered normally.
REQ-063 fetch_pc=0xBFC00002 -> inst_req never asserted; strobe with if_exccode=EXC_ADEL, if_inst=0.
REQ-064 cpu_rst_n low during WAIT -> outputs at reset values before the next clock edge; state IDLE.
REQ-065 fetch_pc=0xFFFFFFFC -> if_pc_plus_4=0x00000000.
